pipe_sched_ctrl: RTL and testbench
==================================

Name: pipe_sched_ctrl

Overview:
- Pipeline scheduling controller for the 5-stage CPU.
- Decides each cycle whether the pipeline advances, holds PC/IR for load-use hazards, inserts a bubble into EX, or squashes the fetched instruction after a taken branch.
- Also provides board-level run/halt/single-step sequencing, so the whole pipeline can be frozen and stepped from push-buttons.
- Sits between ID decode / EX stage status and the IF stage `if_wpcir` input and the pipeline-register enables.

Parameters:
- RESET_RUN, 1, state after reset: 1 = RUN, 0 = HALT.
- CNT_W, 16, width of performance counters (optional feature).

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  reset, asynchronous, active-high.
- id_rs  input  5  rs field of instruction in ID.
- id_rt  input  5  rt field of instruction in ID.
- id_use_rs  input  1  ID instruction reads rs.
- id_use_rt  input  1  ID instruction reads rt.
- ex_wreg  input  1  EX instruction writes the register file.
- ex_m2reg  input  1  EX instruction is a load (LW).
- ex_rd  input  5  destination register of EX instruction.
- ctrl_branch  input  1  branch/jump taken, resolved in ID.
- dbg_run  input  1  one-cycle pulse: enter continuous run.
- dbg_halt  input  1  one-cycle pulse: freeze pipeline.
- dbg_step  input  1  one-cycle pulse: advance exactly one cycle.
- pipe_en  output  1  global advance enable for PC and all pipeline registers.
- if_wpcir  output  1  1 = hold PC and IF/ID register (drives IF stage).
- id_bubble  output  1  1 = force NOP control into ID/EX register.
- if_flush  output  1  1 = load NOP into IF/ID register.
- run_state  output  2  FSM state: 00 HALT, 01 RUN, 10 STEP.
- stall_cnt  output  CNT_W  load-use stall cycles (optional feature).
- flush_cnt  output  CNT_W  branch flushes (optional feature).

Behaviour:
- FSM registered on posedge clk. Reset state is RUN if RESET_RUN=1, else HALT. All counters reset to 0.
- Transitions (priority halt > step > run when pulses coincide):
  - HALT: dbg_step -> STEP; dbg_run -> RUN; else stay.
  - RUN: dbg_halt -> HALT; dbg_step is ignored.
  - STEP: always -> HALT next cycle, unless dbg_run is asserted that cycle -> RUN. dbg_halt in STEP -> HALT.
- pipe_en is combinational from state: 1 in RUN and STEP, 0 in HALT. A step is therefore exactly one advancing clock.
- Load-use hazard (combinational, same cycle):
  - haz = ex_m2reg & ex_wreg & (ex_rd != 0) & ((id_use_rs & id_rs == ex_rd) | (id_use_rt & id_rt == ex_rd)).
- Outputs:
  - if_wpcir = haz | ~pipe_en.
  - id_bubble = haz & pipe_en.
  - if_flush = ctrl_branch & ~haz & pipe_en. A stall takes precedence and the branch is re-evaluated next cycle.
- The stall is one cycle by construction: the bubble clears ex_m2reg on the next cycle.
- HALT freezes everything: no bubble, no flush, and no counter increments.
- Reset mid-step or mid-stall returns to the reset state immediately. Outputs follow the new state combinationally.
- dbg_* are assumed already synchronised and debounced to single-cycle pulses by the board wrapper.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every clk with id_bubble=1.
  - flush_cnt increments on every clk with if_flush=1.
  - Both saturate at all-ones and do not wrap.
  - Both clear on rst and on the HALT->RUN transition.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops are generated.

Test Plan:
- Reset with RESET_RUN=1, no hazards -> run_state=01, pipe_en=1, if_wpcir=0, id_bubble=0, if_flush=0, counters 0.
- RUN; ex_m2reg=1, ex_wreg=1, ex_rd=5, id_use_rt=1, id_rt=5 for one cycle:
  - that cycle: if_wpcir=1, id_bubble=1.
  - next cycle, with ex_m2reg=0: both 0.
  - stall_cnt=1.
  - Repeat with ex_rd=0 -> no stall.
- Same hazard with ctrl_branch=1 simultaneously -> if_flush=0, id_bubble=1. Following cycle with ctrl_branch=1 and no hazard -> if_flush=1, flush_cnt=1.
- dbg_halt pulse -> HALT: pipe_en=0, if_wpcir=1.
  - dbg_step -> exactly one cycle with run_state=10 and pipe_en=1, then HALT.
  - dbg_step and dbg_halt in the same cycle -> stays HALT.
- In HALT, dbg_run -> RUN next cycle and counters cleared to 0.
  - Force 2^CNT_W+3 consecutive hazard cycles -> stall_cnt holds at all-ones.
- Assert rst asynchronously mid-STEP -> state and counters reset immediately, without waiting for clk.

Source files
------------

// File: rtl/pipe_sched_ctrl.sv
// pipe_sched_ctrl: pipeline scheduling controller for the 5-stage CPU.
// Produces the global advance enable and the IF/ID hold, ID/EX bubble and
// IF/ID flush controls. It also sequences run/halt/single-step from
// debounced board pulses.
// Optional build macro PIPE_PERF_CNT_EN adds saturating stall/flush counters.
// Without the macro, stall_cnt/flush_cnt are constant zero.
module pipe_sched_ctrl #(
   parameter bit RESET_RUN = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             ex_wreg,
   input  logic             ex_m2reg,
   input  logic [4:0]       ex_rd,
   input  logic             ctrl_branch,
   input  logic             dbg_run,
   input  logic             dbg_halt,
   input  logic             dbg_step,
   output logic             pipe_en,
   output logic             if_wpcir,
   output logic             id_bubble,
   output logic             if_flush,
   output logic [1:0]       run_state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      S_HALT = 2'b00,
      S_RUN  = 2'b01,
      S_STEP = 2'b10
   } state_e;

   localparam state_e RESET_STATE = RESET_RUN ? S_RUN : S_HALT;

   state_e state_q;
   logic   haz;

   // Run/halt/step sequencer; halt beats step beats run when pulses coincide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RESET_STATE;
      end else begin
         case (state_q)
            S_HALT: begin
               if (dbg_halt)      state_q <= S_HALT;
               else if (dbg_step) state_q <= S_STEP;
               else if (dbg_run)  state_q <= S_RUN;
               else               state_q <= S_HALT;
            end
            S_RUN: begin
               if (dbg_halt) state_q <= S_HALT;
               else          state_q <= S_RUN;
            end
            S_STEP: begin
               if (!dbg_halt && !dbg_step && dbg_run) state_q <= S_RUN;
               else                                   state_q <= S_HALT;
            end
            default: state_q <= RESET_STATE;
         endcase
      end
   end

   // Load-use hazard detect and the per-cycle pipeline controls it gates.
   always_comb begin
      haz = ex_m2reg && ex_wreg && (ex_rd != 5'd0) &&
            ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
      pipe_en   = (state_q != S_HALT);
      if_wpcir  = haz || !pipe_en;
      id_bubble = haz && pipe_en;
      // A stalled branch is seen again next cycle, so the flush waits for it.
      if_flush  = ctrl_branch && !haz && pipe_en;
      run_state = state_q;
   end

`ifdef PIPE_PERF_CNT_EN
   logic             halt_to_run;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   // The HALT->RUN edge starts a fresh measurement window.
   always_comb begin
      halt_to_run = (state_q == S_HALT) && !dbg_halt && !dbg_step && dbg_run;
   end

   // Saturating event counters; HALT never increments because both events need pipe_en.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else if (halt_to_run) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (id_bubble && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_q <= stall_cnt_q + 1'b1;
         if (if_flush  && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_sched_ctrl.sv
// tb_pipe_sched_ctrl: directed bench for pipe_sched_ctrl with a behavioural
// reference model and a per-cycle comparator, plus literal spot checks.
module tb_pipe_sched_ctrl;
   localparam bit RESET_RUN = 1'b1;
   localparam int CNT_W     = 4;
   localparam int SAT       = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       id_rs, id_rt, ex_rd;
   logic             id_use_rs, id_use_rt, ex_wreg, ex_m2reg, ctrl_branch;
   logic             dbg_run, dbg_halt, dbg_step;
   logic             pipe_en, if_wpcir, id_bubble, if_flush;
   logic [1:0]       run_state;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   // Reference model: mode 0=HALT 1=RUN 2=STEP, plain integer counters
   int m_mode, m_stall, m_flush;

   pipe_sched_ctrl #(.RESET_RUN(RESET_RUN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rd(ex_rd), .ctrl_branch(ctrl_branch),
      .dbg_run(dbg_run), .dbg_halt(dbg_halt), .dbg_step(dbg_step),
      .pipe_en(pipe_en), .if_wpcir(if_wpcir), .id_bubble(id_bubble), .if_flush(if_flush),
      .run_state(run_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit haz_f();
      return ex_m2reg && ex_wreg && (ex_rd != 5'd0) &&
             ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
   endfunction

   function automatic int cnt_exp(input int v);
`ifdef PIPE_PERF_CNT_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   // Model update at each clock edge / asynchronous reset
   always @(posedge clk or posedge rst) begin : model
      int  nxt;
      bit  adv, h;
      if (rst) begin
         m_mode  <= RESET_RUN ? 1 : 0;
         m_stall <= 0;
         m_flush <= 0;
      end else begin
         adv = (m_mode != 0);
         h   = haz_f();
         if (adv && h && m_stall < SAT)                 m_stall <= m_stall + 1;
         if (adv && !h && ctrl_branch && m_flush < SAT) m_flush <= m_flush + 1;
         if (m_mode == 0) begin
            nxt = dbg_halt ? 0 : dbg_step ? 2 : dbg_run ? 1 : 0;
            if (nxt == 1) begin
               m_stall <= 0;
               m_flush <= 0;
            end
         end else if (m_mode == 1) begin
            nxt = dbg_halt ? 0 : 1;
         end else begin
            nxt = (!dbg_halt && !dbg_step && dbg_run) ? 1 : 0;
         end
         m_mode <= nxt;
      end
   end

   // Per-cycle comparator on the falling edge
   always @(negedge clk) begin
      bit en, h;
      if (chk_on) begin
         en = (m_mode != 0);
         h  = haz_f();
         chk("run_state", run_state, m_mode);
         chk("pipe_en",   pipe_en,   en);
         chk("if_wpcir",  if_wpcir,  h || !en);
         chk("id_bubble", id_bubble, h && en);
         chk("if_flush",  if_flush,  ctrl_branch && !h && en);
         chk("stall_cnt", stall_cnt, cnt_exp(m_stall));
         chk("flush_cnt", flush_cnt, cnt_exp(m_flush));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_load_hazard(input logic [4:0] rd);
      ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_rd = rd;
   endtask

   initial begin
      id_rs = '0; id_rt = '0; ex_rd = '0;
      id_use_rs = 0; id_use_rt = 0; ex_wreg = 0; ex_m2reg = 0; ctrl_branch = 0;
      dbg_run = 0; dbg_halt = 0; dbg_step = 0;
      rst = 1'b0;
      #1 rst = 1'b1;
      chk_on = 1'b1;
      tick(2);
      chk("rst_state",   run_state, 1);
      chk("rst_pipe_en", pipe_en,   1);
      chk("rst_wpcir",   if_wpcir,  0);
      chk("rst_bubble",  id_bubble, 0);
      chk("rst_flush",   if_flush,  0);
      chk("rst_stall",   stall_cnt, 0);
      chk("rst_fcnt",    flush_cnt, 0);
      rst = 1'b0;
      tick(1);

      // Load-use hazard on rt
      set_load_hazard(5'd5); id_use_rt = 1; id_rt = 5'd5;
      #1;
      chk("haz_wpcir",  if_wpcir,  1);
      chk("haz_bubble", id_bubble, 1);
      tick(1);
      ex_m2reg = 0;
      #1;
      chk("post_wpcir",  if_wpcir,  0);
      chk("post_bubble", id_bubble, 0);
      chk("post_stall",  stall_cnt, cnt_exp(1));
      tick(1);

      // r0 destination never stalls
      set_load_hazard(5'd0); id_rt = 5'd0;
      #1;
      chk("r0_bubble", id_bubble, 0);
      tick(1);

      // Hazard on rs with simultaneous branch: stall wins
      id_use_rt = 0; id_rt = 5'd3;
      set_load_hazard(5'd7); id_use_rs = 1; id_rs = 5'd7; ctrl_branch = 1;
      #1;
      chk("hb_flush",  if_flush,  0);
      chk("hb_bubble", id_bubble, 1);
      tick(1);
      ex_m2reg = 0;
      #1;
      chk("br_flush", if_flush, 1);
      tick(1);
      chk("br_fcnt", flush_cnt, cnt_exp(1));
      ctrl_branch = 0; id_use_rs = 0;

      // dbg_step is ignored while running
      dbg_step = 1; tick(1); dbg_step = 0;
      chk("run_ign_step", run_state, 1);

      // Halt, single step, step+halt
      dbg_halt = 1; tick(1); dbg_halt = 0;
      chk("halt_state", run_state, 0);
      chk("halt_en",    pipe_en,   0);
      chk("halt_wpcir", if_wpcir,  1);
      dbg_step = 1; tick(1); dbg_step = 0;
      chk("step_state", run_state, 2);
      chk("step_en",    pipe_en,   1);
      tick(1);
      chk("step_back",  run_state, 0);
      dbg_step = 1; dbg_halt = 1; tick(1); dbg_step = 0; dbg_halt = 0;
      chk("stephalt_state", run_state, 0);

      // Hazard and branch while halted do nothing
      set_load_hazard(5'd9); id_use_rt = 1; id_rt = 5'd9; ctrl_branch = 1;
      tick(2);
      chk("halt_stall_hold", stall_cnt, cnt_exp(2));
      ex_m2reg = 0; ctrl_branch = 0;

      // Resume clears counters
      dbg_run = 1; tick(1); dbg_run = 0;
      chk("run_state", run_state, 1);
      chk("run_stall", stall_cnt, 0);
      chk("run_fcnt",  flush_cnt, 0);

      // Saturation of the stall counter
      set_load_hazard(5'd9);
      tick((1 << CNT_W) + 3);
      ex_m2reg = 0;
      chk("sat_stall", stall_cnt, cnt_exp(SAT));
      ctrl_branch = 1; tick(2); ctrl_branch = 0;
      chk("two_flush", flush_cnt, cnt_exp(2));

      // Asynchronous reset in the middle of a step
      dbg_halt = 1; tick(1); dbg_halt = 0;
      dbg_step = 1; tick(1); dbg_step = 0;
      chk("pre_rst_step", run_state, 2);
      #2 rst = 1'b1;
      #1;
      chk("arst_state", run_state, 1);
      chk("arst_en",    pipe_en,   1);
      chk("arst_stall", stall_cnt, 0);
      chk("arst_fcnt",  flush_cnt, 0);
      tick(1);
      rst = 1'b0;
      tick(2);
      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop guard
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
